// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
// Holds the FSM, owner and operation encodings plus the load/store decode helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_e;

    typedef enum logic {
        OWN_IMEM,
        OWN_DMEM
    } owner_e;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_ERR
    } op_e;

    // A simultaneous load and store request is meaningless and is answered with an error.
    function automatic op_e decode_dmem_op(input logic ren, input logic wen);
        if (ren && wen) begin
            return OP_ERR;
        end
        if (wen) begin
            return OP_WRITE;
        end
        return OP_READ;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Single handshaked memory port shared by fetch and load/store.
// The master side is the arbiter and the slave side is the memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  o_mem_ren;
    logic                  o_mem_wen;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic [DATA_W-1:0]     o_mem_wdata;
    logic [DATA_W/8-1:0]   o_mem_mask;
    logic                  i_mem_ready;
    logic                  i_mem_valid;
    logic [DATA_W-1:0]     i_mem_rdata;

    modport master (
        output o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        input  i_mem_ready, i_mem_valid, i_mem_rdata
    );

    modport slave (
        input  o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        output i_mem_ready, i_mem_valid, i_mem_rdata
    );
endinterface

// File: rtl/mem_arb_grant.sv
// Combinational grant picker: data side wins by default, fetch wins a tie
// when the previous grant went to the data side so fetch cannot starve.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   i_imem_req,
    input  logic   i_dmem_req,
    input  owner_e i_last_grant,
    output logic   o_grant_imem,
    output logic   o_grant_dmem
);
    logic w_imem_wins;

    assign w_imem_wins  = i_imem_req && (!i_dmem_req || (i_last_grant == OWN_DMEM));
    assign o_grant_imem = w_imem_wins;
    assign o_grant_dmem = i_dmem_req && !w_imem_wins;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store traffic onto one handshaked memory port,
// one outstanding transaction at a time, with per-requester completion pulses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_imem_req,
    input  logic [ADDR_W-1:0]   i_imem_addr,
    output logic                o_imem_valid,
    output logic [DATA_W-1:0]   o_imem_rdata,
    input  logic                i_dmem_ren,
    input  logic                i_dmem_wen,
    input  logic [ADDR_W-1:0]   i_dmem_addr,
    input  logic [DATA_W-1:0]   i_dmem_wdata,
    input  logic [DATA_W/8-1:0] i_dmem_mask,
    output logic                o_dmem_done,
    output logic                o_dmem_err,
    output logic [DATA_W-1:0]   o_dmem_rdata,
    mem_arbiter_if.master       mem
);
    state_e              r_state;
    state_e              w_state_next;
    owner_e              r_owner;
    owner_e              r_last_grant;
    op_e                 r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_mask;

    logic w_dmem_req;
    logic w_grant_imem;
    logic w_grant_dmem;
    logic w_grant;

    assign w_dmem_req = i_dmem_ren || i_dmem_wen;
    assign w_grant    = (r_state == IDLE) && (w_grant_imem || w_grant_dmem);

    mem_arb_grant u_grant (
        .i_imem_req   (i_imem_req),
        .i_dmem_req   (w_dmem_req),
        .i_last_grant (r_last_grant),
        .o_grant_imem (w_grant_imem),
        .o_grant_dmem (w_grant_dmem)
    );

    // State register plus the request fields captured at grant time.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IMEM;
            r_last_grant <= OWN_IMEM;
            r_op         <= OP_READ;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                if (w_grant_imem) begin
                    r_owner      <= OWN_IMEM;
                    r_last_grant <= OWN_IMEM;
                    r_op         <= OP_READ;
                    r_addr       <= i_imem_addr;
                    r_wdata      <= '0;
                    r_mask       <= '0;
                end else begin
                    r_owner      <= OWN_DMEM;
                    r_last_grant <= OWN_DMEM;
                    r_op         <= decode_dmem_op(i_dmem_ren, i_dmem_wen);
                    r_addr       <= i_dmem_addr;
                    r_wdata      <= i_dmem_wdata;
                    r_mask       <= i_dmem_mask;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (r_op == OP_ERR) begin
                    w_state_next = IDLE;
                end else if (mem.i_mem_ready) begin
                    w_state_next = (r_op == OP_WRITE) ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem.i_mem_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Everything is forced low while reset is held so an abandoned transaction never completes.
    always_comb begin
        mem.o_mem_ren   = 1'b0;
        mem.o_mem_wen   = 1'b0;
        mem.o_mem_addr  = '0;
        mem.o_mem_wdata = '0;
        mem.o_mem_mask  = '0;
        o_imem_valid    = 1'b0;
        o_imem_rdata    = '0;
        o_dmem_done     = 1'b0;
        o_dmem_err      = 1'b0;
        o_dmem_rdata    = '0;
        if (!i_rst) begin
            case (r_state)
                REQ: begin
                    if (r_op == OP_ERR) begin
                        o_dmem_done = 1'b1;
                        o_dmem_err  = 1'b1;
                    end else begin
                        mem.o_mem_ren   = (r_op == OP_READ);
                        mem.o_mem_wen   = (r_op == OP_WRITE);
                        mem.o_mem_addr  = r_addr;
                        mem.o_mem_wdata = r_wdata;
                        mem.o_mem_mask  = r_mask;
                        o_dmem_done     = (r_op == OP_WRITE) && mem.i_mem_ready;
                    end
                end
                WAIT: begin
                    if (mem.i_mem_valid) begin
                        if (r_owner == OWN_IMEM) begin
                            o_imem_valid = 1'b1;
                            o_imem_rdata = mem.i_mem_rdata;
                        end else begin
                            o_dmem_done  = 1'b1;
                            o_dmem_rdata = mem.i_mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions into a
// scoreboard queue, a monitor pops them on every completion pulse, a small memory model answers.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        dmem_done;
    logic        dmem_err;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_imem_req   (imem_req),
        .i_imem_addr  (imem_addr),
        .o_imem_valid (imem_valid),
        .o_imem_rdata (imem_rdata),
        .i_dmem_ren   (dmem_ren),
        .i_dmem_wen   (dmem_wen),
        .i_dmem_addr  (dmem_addr),
        .i_dmem_wdata (dmem_wdata),
        .i_dmem_mask  (dmem_mask),
        .o_dmem_done  (dmem_done),
        .o_dmem_err   (dmem_err),
        .o_dmem_rdata (dmem_rdata),
        .mem          (mem_bus)
    );

    typedef struct {
        bit          is_dmem;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          ready_delay = 0;
    bit          hold_resp = 1'b0;
    bit          spur_valid = 1'b0;
    logic [31:0] spur_data = 32'h0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h0000_0013;
            32'h0000_0044: return 32'h0000_0093;
            32'h0000_2000: return 32'h1234_5678;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] out_flags();
        return {27'd0, imem_valid, dmem_done, dmem_err, mem_bus.o_mem_ren, mem_bus.o_mem_wen};
    endfunction

    function automatic bit all_zero();
        return (out_flags() == 32'd0) && (imem_rdata == 32'd0) && (dmem_rdata == 32'd0)
            && (mem_bus.o_mem_addr == 32'd0) && (mem_bus.o_mem_wdata == 32'd0)
            && (mem_bus.o_mem_mask == 4'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pulse(input bit is_dmem, input logic [31:0] rdata, input bit err);
        exp_t e;
        if (sb.size() == 0) begin
            chk(1'b0, "unexpected_pulse", {31'd0, is_dmem}, 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk(e.is_dmem == is_dmem, "pulse_owner", {31'd0, is_dmem}, {31'd0, e.is_dmem});
            chk(e.rdata == rdata, "pulse_rdata", rdata, e.rdata);
            chk(e.err == err, "pulse_err", {31'd0, err}, {31'd0, e.err});
            $display("TXN %s rdata=0x%08h err=%0d t=%0t", is_dmem ? "dmem" : "imem", rdata, err, $time);
        end
    endtask

    initial begin
        rst        = 1'b1;
        imem_req   = 1'b0;
        imem_addr  = 32'h0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        dmem_mask  = 4'h0;
        mem_bus.i_mem_ready = 1'b0;
        mem_bus.i_mem_valid = 1'b0;
        mem_bus.i_mem_rdata = 32'h0;
        fork
            begin : stimulus
                int done_cnt;
                // Reset with requests pending: nothing may leak out.
                imem_req = 1'b1;
                dmem_wen = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk(all_zero(), "reset_outputs_zero", out_flags(), 32'd0);
                    tick();
                end
                rst = 1'b0;
                imem_req = 1'b0;
                dmem_wen = 1'b0;
                @(negedge clk);
                chk(all_zero(), "idle_after_reset", out_flags(), 32'd0);

                // Single fetch: request at N, mem_ren at N+1, valid at N+2.
                tick();
                imem_req  = 1'b1;
                imem_addr = 32'h0000_0040;
                sb.push_back('{1'b0, 32'h0000_0013, 1'b0});
                tick();
                @(negedge clk);
                chk(mem_bus.o_mem_ren && !mem_bus.o_mem_wen, "fetch_ren", out_flags(), 32'd2);
                chk(mem_bus.o_mem_addr == 32'h40, "fetch_addr", mem_bus.o_mem_addr, 32'h40);
                tick();
                @(negedge clk);
                chk(imem_valid && !dmem_done, "fetch_valid_n2", out_flags(), 32'd16);
                tick();
                imem_req = 1'b0;

                // Contention: continuous fetch and load, expect D, I, D, I.
                ready_delay = 1;
                sb.push_back('{1'b1, 32'h1234_5678, 1'b0});
                sb.push_back('{1'b0, 32'h0000_0093, 1'b0});
                sb.push_back('{1'b1, 32'h1234_5678, 1'b0});
                sb.push_back('{1'b0, 32'h0000_0093, 1'b0});
                tick();
                imem_req  = 1'b1;
                imem_addr = 32'h0000_0044;
                dmem_ren  = 1'b1;
                dmem_addr = 32'h0000_2000;
                done_cnt  = 0;
                for (int c = 0; c < 200 && done_cnt < 4; c++) begin
                    @(negedge clk);
                    if (imem_valid || dmem_done) done_cnt++;
                end
                chk(done_cnt == 4, "contention_completions", done_cnt, 32'd4);
                tick();
                imem_req = 1'b0;
                dmem_ren = 1'b0;

                // Store with three cycles of backpressure; fields must hold.
                ready_delay = 3;
                tick();
                dmem_wen   = 1'b1;
                dmem_addr  = 32'h0000_1000;
                dmem_wdata = 32'hAABB_CCDD;
                dmem_mask  = 4'b1100;
                sb.push_back('{1'b1, 32'h0, 1'b0});
                for (int k = 0; k < 4; k++) begin
                    tick();
                    if (k == 1) begin
                        dmem_addr  = 32'h0000_2FF0;
                        dmem_wdata = 32'h0;
                    end
                    @(negedge clk);
                    chk(mem_bus.o_mem_wen && !mem_bus.o_mem_ren, "store_wen_held", out_flags(), 32'd1);
                    chk(mem_bus.o_mem_addr == 32'h1000, "store_addr_held", mem_bus.o_mem_addr, 32'h1000);
                    chk(mem_bus.o_mem_wdata == 32'hAABB_CCDD, "store_wdata_held", mem_bus.o_mem_wdata, 32'hAABB_CCDD);
                    chk(mem_bus.o_mem_mask == 4'b1100, "store_mask_held", {28'd0, mem_bus.o_mem_mask}, 32'hC);
                    chk(dmem_done == (k == 3), "store_done_timing", {31'd0, dmem_done}, {31'd0, k == 3});
                end
                tick();
                dmem_wen = 1'b0;

                // Illegal ren+wen: no memory access, done+err one cycle later.
                ready_delay = 0;
                tick();
                dmem_ren  = 1'b1;
                dmem_wen  = 1'b1;
                dmem_addr = 32'h0000_3000;
                sb.push_back('{1'b1, 32'h0, 1'b1});
                @(negedge clk);
                chk(out_flags() == 32'd0, "illegal_quiet_n", out_flags(), 32'd0);
                tick();
                @(negedge clk);
                chk(out_flags() == 32'd12, "illegal_done_err_n1", out_flags(), 32'd12);
                tick();
                dmem_ren = 1'b0;
                dmem_wen = 1'b0;
                @(negedge clk);
                chk(out_flags() == 32'd0, "illegal_single_pulse", out_flags(), 32'd0);

                // Spurious response while idle is ignored.
                tick();
                spur_valid = 1'b1;
                spur_data  = 32'hCAFE_F00D;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk(!imem_valid && !dmem_done, "spurious_ignored", out_flags(), 32'd0);
                    tick();
                end
                spur_valid = 1'b0;

                // Reset while waiting for a read response, then a late response.
                hold_resp = 1'b1;
                tick();
                imem_req  = 1'b1;
                imem_addr = 32'h0000_0048;
                tick();
                @(negedge clk);
                chk(mem_bus.o_mem_ren, "rstwait_ren", out_flags(), 32'd2);
                tick();
                @(negedge clk);
                chk(out_flags() == 32'd0, "rstwait_in_wait", out_flags(), 32'd0);
                tick();
                rst = 1'b1;
                @(negedge clk);
                chk(all_zero(), "rstwait_outputs_zero", out_flags(), 32'd0);
                tick();
                rst        = 1'b0;
                imem_req   = 1'b0;
                hold_resp  = 1'b0;
                spur_valid = 1'b1;
                spur_data  = 32'h0000_0013;
                @(negedge clk);
                chk(all_zero(), "late_response_ignored", out_flags(), 32'd0);
                tick();
                spur_valid = 1'b0;
                @(negedge clk);
                chk(all_zero(), "idle_after_abandon", out_flags(), 32'd0);

                // Recovery fetch after the abandoned transaction.
                tick();
                imem_req  = 1'b1;
                imem_addr = 32'h0000_0040;
                sb.push_back('{1'b0, 32'h0000_0013, 1'b0});
                tick();
                tick();
                @(negedge clk);
                chk(imem_valid, "recovery_fetch_n2", out_flags(), 32'd16);
                tick();
                imem_req = 1'b0;
                for (int k = 0; k < 3; k++) tick();
                chk(sb.size() == 0, "scoreboard_drained", sb.size(), 32'd0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    chk(!(mem_bus.o_mem_ren && mem_bus.o_mem_wen), "ren_wen_exclusive", out_flags(), 32'd0);
                    if (!imem_valid) chk(imem_rdata == 32'd0, "imem_rdata_zero", imem_rdata, 32'd0);
                    if (!dmem_done) chk(dmem_rdata == 32'd0 && !dmem_err, "dmem_rdata_err_zero", dmem_rdata, 32'd0);
                    if (imem_valid) check_pulse(1'b0, imem_rdata, 1'b0);
                    if (dmem_done) check_pulse(1'b1, dmem_rdata, dmem_err);
                end
            end
            begin : memory_model
                bit          pending;
                logic [31:0] pdata;
                int          wait_cnt;
                pending  = 1'b0;
                pdata    = 32'h0;
                wait_cnt = 0;
                forever begin
                    @(posedge clk);
                    #2;
                    if (rst) begin
                        pending  = 1'b0;
                        wait_cnt = 0;
                        mem_bus.i_mem_ready = 1'b0;
                        mem_bus.i_mem_valid = 1'b0;
                        mem_bus.i_mem_rdata = 32'h0;
                    end else begin
                        mem_bus.i_mem_valid = pending || spur_valid;
                        mem_bus.i_mem_rdata = pending ? pdata : (spur_valid ? spur_data : 32'h0);
                        pending = 1'b0;
                        mem_bus.i_mem_ready = 1'b0;
                        if (mem_bus.o_mem_ren || mem_bus.o_mem_wen) begin
                            if (wait_cnt < ready_delay) begin
                                wait_cnt++;
                            end else begin
                                mem_bus.i_mem_ready = 1'b1;
                                wait_cnt = 0;
                                if (mem_bus.o_mem_ren && !hold_resp) begin
                                    pending = 1'b1;
                                    pdata   = mem_word(mem_bus.o_mem_addr);
                                end
                            end
                        end
                    end
                end
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single realistic (multi-cycle, handshaked) memory port between the hart's instruction-fetch side and its data load/store side. It replaces the idealised combinational imem/dmem ports with one arbitrated port. It serialises requests with a small FSM and keeps one transaction outstanding at a time. It sits between the hart and the unified memory model, and returns per-requester completion pulses so the pipeline can stall.

## Interface
Parameters:
- ADDR_W, 32, address width (word-aligned; bits [1:0] forwarded unchanged).
- DATA_W, 32, data width.

Ports:
- i_clk  in  1  global clock.
- i_rst  in  1  synchronous active-high reset.
- i_imem_req  in  1  fetch request; held until o_imem_valid.
- i_imem_addr  in  32  fetch address.
- o_imem_valid  out  1  one-cycle pulse: o_imem_rdata valid, fetch complete.
- o_imem_rdata  out  32  fetched word.
- i_dmem_ren  in  1  load request; held until o_dmem_done.
- i_dmem_wen  in  1  store request; held until o_dmem_done.
- i_dmem_addr  in  32  aligned data address.
- i_dmem_wdata  in  32  store data (already lane-shifted).
- i_dmem_mask  in  4  byte-lane mask.
- o_dmem_done  out  1  one-cycle pulse: load data valid, or store accepted.
- o_dmem_err  out  1  valid with o_dmem_done; set for an illegal ren&wen request.
- o_dmem_rdata  out  32  load data.
- o_mem_ren, o_mem_wen  out  1  memory read/write request.
- o_mem_addr  out  32, o_mem_wdata out 32, o_mem_mask out 4  memory request fields.
- i_mem_ready  in  1  memory accepts the request this cycle.
- i_mem_valid  in  1  read response valid.
- i_mem_rdata  in  32  read response data.

## Operation
- FSM states: IDLE, REQ, WAIT. A registered owner field (IMEM/DMEM) and a registered last_grant bit.
- IDLE: pick a requester; latch owner, addr, wdata, mask, and op into registers; go to REQ. No request means stay in IDLE.
- Grant rule: DMEM wins by default. IMEM wins when both are pending and last_grant==DMEM, which prevents fetch starvation. last_grant updates on every grant.
- REQ: drive o_mem_ren or o_mem_wen with the latched fields.
  - If i_mem_ready=0, hold all fields stable.
  - If i_mem_ready=1 and op=write, pulse o_dmem_done in the same cycle and go to IDLE.
  - If i_mem_ready=1 and op=read, go to WAIT.
- WAIT: no memory request is driven.
  - On i_mem_valid, pass i_mem_rdata combinationally to the owner's rdata and pulse the owner's valid/done in the same cycle.
  - Then go to IDLE.
- i_mem_valid outside WAIT is ignored.
- Illegal request (i_dmem_ren & i_dmem_wen): no memory access. Pulse o_dmem_done with o_dmem_err=1 on the cycle after it is seen in IDLE. Counts as a DMEM grant.
- o_mem_ren and o_mem_wen are never asserted together.
- o_imem_rdata and o_dmem_rdata are 0 when their valid/done is low.

## Timing
- Reset:
  - State=IDLE, last_grant=IMEM, all latched fields=0.
  - Every output is 0 during and after the reset cycle; outputs are gated by ~i_rst.
- Reset mid-REQ or mid-WAIT: the transaction is abandoned and no completion pulse is issued. The memory shares i_rst, so no stale response can arrive.
- Request sampled in IDLE at cycle N: o_mem_* asserted at N+1.
  - Zero-wait store: o_dmem_done at N+1.
  - Read with 0-cycle ready and 1-cycle response: valid at N+2.
- After a completion pulse the FSM is in IDLE. The next grant's o_mem_* asserts two cycles after the completion cycle at the earliest. There is no bypass.
- Requesters must keep their inputs stable until completion. Fields are latched, so changes after the grant are ignored anyway.
- Simultaneous new requests while busy are held off; requesters see no completion pulse.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, REQ, WAIT}.
  - owner enum {OWN_IMEM, OWN_DMEM}.
  - op enum {OP_READ, OP_WRITE, OP_ERR}.
- One sub-module, mem_arb_grant: combinational grant picker (imem_req, dmem_req, last_grant → grant_imem, grant_dmem).
- All state and latched fields live in mem_arbiter.

## Test plan
- Single fetch: i_imem_req at 0x0000_0040, ready=1, response 0x0000_0013 one cycle later → o_mem_ren=1 with addr 0x40; o_imem_valid pulses with rdata 0x13 at N+2; o_dmem_done stays 0.
- Store with backpressure: wen, addr 0x1000, wdata 0xAABB_CCDD, mask 0b1100, i_mem_ready low for 3 cycles → fields held stable; one o_dmem_done pulse on the ready cycle; no o_mem_ren.
- Contention: imem and dmem load requested continuously.
  - Grants alternate DMEM, IMEM, DMEM, IMEM.
  - Each requester gets exactly one pulse per transaction.
  - o_mem_ren/o_mem_wen are never both high.
- Illegal request: ren=wen=1 → no o_mem_* activity; o_dmem_done=1 with o_dmem_err=1 one cycle later.
- Reset in WAIT: i_rst asserted while awaiting response, then a late i_mem_valid → no valid/done pulse; state IDLE; all outputs 0.
- Spurious response: i_mem_valid=1 while IDLE → ignored; no pulses.
